// File: rtl/alu_sched_pkg.sv
// Shared types for the ALU scheduler: the packed requester command, the
// scheduler FSM encoding and the widths both are built from.
package alu_sched_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int OP_WIDTH_DEF   = 3;
    localparam int LAT_WIDTH      = 4;  // holds ALU_LATENCY 0..15

    typedef struct packed {
        logic [DATA_WIDTH_DEF-1:0] data_1;
        logic [DATA_WIDTH_DEF-1:0] data_2;
        logic [OP_WIDTH_DEF-1:0]   op;
        logic [OP_WIDTH_DEF-1:0]   sel;
        logic                      arith;
        logic                      shift;
    } alu_cmd_t;

    localparam int CMD_W = $bits(alu_cmd_t);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } sched_state_t;

endpackage

// File: rtl/alu_scheduler_rr_arbiter.sv
// Combinational rotating-priority arbiter: the first asserted request found
// when scanning upward from ptr_i (wrapping at NUM_REQ) wins.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDW-1:0]     grant_idx_o,
    output logic               any_o
);

    localparam int SW = IDW + 1;

    logic [SW-1:0]  sum;
    logic [IDW-1:0] idx;

    // NOTE: every output and temporary gets a default before the loop, so no
    // path through this block leaves a value unassigned and no latch appears.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        sum         = '0;
        idx         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr_i} + SW'(k);
            if (sum >= SW'(NUM_REQ)) begin
                sum = sum - SW'(NUM_REQ);
            end
            idx = sum[IDW-1:0];
            if (!any_o && req_i[idx]) begin
                any_o          = 1'b1;
                grant_idx_o    = idx;
                grant_o[idx]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one ALU among NUM_REQ requesters: round-robin command intake, a
// fixed-latency wait for the ALU, then a held response tagged with the owner.
module alu_scheduler
    import alu_sched_pkg::*;
#(
    parameter  int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter  int OP_WIDTH    = OP_WIDTH_DEF,
    parameter  int NUM_REQ     = 4,
    parameter  int ALU_LATENCY = 1,
    localparam int IDW         = $clog2(NUM_REQ)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*CMD_W-1:0] req_cmd,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [DATA_WIDTH-1:0]    rsp_data,
    output logic [DATA_WIDTH-1:0]    alu_data_1,
    output logic [DATA_WIDTH-1:0]    alu_data_2,
    output logic [OP_WIDTH-1:0]      alu_op,
    output logic [OP_WIDTH-1:0]      alu_sel,
    output logic                     alu_arith,
    output logic                     alu_shift,
    input  logic [DATA_WIDTH-1:0]    alu_data_out
);

    sched_state_t            state_q, state_d;
    logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]          gnt_id_q, gnt_id_d;
    logic [LAT_WIDTH-1:0]    wait_cnt_q, wait_cnt_d;
    alu_cmd_t                cmd_q, cmd_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;

    logic [NUM_REQ-1:0]      arb_grant;
    logic [IDW-1:0]          arb_idx;
    logic                    arb_any;
    alu_cmd_t                gnt_cmd;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i       (req_valid),
        .ptr_i       (rr_ptr_q),
        .grant_o     (arb_grant),
        .grant_idx_o (arb_idx),
        .any_o       (arb_any)
    );

    always_comb begin
        gnt_cmd = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IDW'(i)) begin
                gnt_cmd = req_cmd[i*CMD_W +: CMD_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_id_d   = gnt_id_q;
        wait_cnt_d = wait_cnt_q;
        cmd_d      = cmd_q;
        rsp_data_d = rsp_data_q;
        req_ready  = '0;

        unique case (state_q)
            IDLE: begin
                // Ready is withheld while reset is low so nothing handshakes
                // in a cycle the registers are about to discard.
                req_ready = reset ? arb_grant : '0;
                if (arb_any) begin
                    cmd_d    = gnt_cmd;
                    gnt_id_d = arb_idx;
                    rr_ptr_d = (arb_idx == IDW'(NUM_REQ - 1)) ? '0 : arb_idx + IDW'(1);
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                wait_cnt_d = LAT_WIDTH'(ALU_LATENCY);
                if (ALU_LATENCY == 0) begin
                    rsp_data_d = alu_data_out;
                    state_d    = RESP;
                end else begin
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                wait_cnt_d = wait_cnt_q - LAT_WIDTH'(1);
                if (wait_cnt_q == LAT_WIDTH'(1)) begin
                    rsp_data_d = alu_data_out;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // here samples the pre-edge values of the others.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            gnt_id_q   <= '0;
            wait_cnt_q <= '0;
            // NOTE: the command and result registers are reset as well, since
            // they drive alu_* and rsp_data directly and must read zero.
            cmd_q      <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_id_q   <= gnt_id_d;
            wait_cnt_q <= wait_cnt_d;
            cmd_q      <= cmd_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = gnt_id_q;
    assign rsp_data   = rsp_data_q;
    assign alu_data_1 = cmd_q.data_1;
    assign alu_data_2 = cmd_q.data_2;
    assign alu_op     = cmd_q.op;
    assign alu_sel    = cmd_q.sel;
    assign alu_arith  = cmd_q.arith;
    assign alu_shift  = cmd_q.shift;

endmodule

// File: tb/tb_alu_scheduler.sv
// Bench for alu_scheduler: three instances (ALU latency 1, 0 and 4), each fed by
// a behavioural ALU that only presents its result in the cycle it is due.
`timescale 1ns/1ps
module tb_alu_scheduler;
    import alu_sched_pkg::*;

    localparam int NI = 3;
    localparam int NR = 4;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 0 : 4;
    endfunction

    function automatic logic [31:0] alu_f(input alu_cmd_t c);
        case (c.op)
            3'd0:    return c.data_1 + c.data_2;
            3'd1:    return c.data_1 - c.data_2;
            3'd2:    return c.data_1 & c.data_2;
            3'd3:    return c.data_1 | c.data_2;
            3'd4:    return c.data_1 ^ c.data_2;
            default: return c.data_1;
        endcase
    endfunction

    function automatic int model_pick(input logic [NR-1:0] v, input int ptr);
        for (int k = 0; k < NR; k++) begin
            if (v[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    function automatic alu_cmd_t rand_cmd();
        alu_cmd_t c;
        c.data_1 = $urandom;
        c.data_2 = $urandom;
        c.op     = 3'($urandom_range(0, 7));
        c.sel    = 3'($urandom_range(0, 7));
        c.arith  = 1'($urandom_range(0, 1));
        c.shift  = 1'($urandom_range(0, 1));
        return c;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [NR-1:0]     req_valid_a [NI];
    logic [NR*CMD_W-1:0] req_cmd_a [NI];
    logic              rsp_ready_a [NI];
    logic [NR-1:0]     req_ready_w [NI];
    logic              rsp_valid_w [NI];
    logic [1:0]        rsp_id_w    [NI];
    logic [31:0]       rsp_data_w  [NI];
    logic [31:0]       d1_w        [NI];
    logic [31:0]       d2_w        [NI];
    logic [2:0]        op_w        [NI];
    logic [2:0]        sel_w       [NI];
    logic              arith_w     [NI];
    logic              shift_w     [NI];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar k = 0; k < NI; k++) begin : g_inst
        localparam int L = lat_of(k);
        int          hs_cyc = -100;
        alu_cmd_t    alu_in;
        logic [31:0] dout;

        assign alu_in = {d1_w[k], d2_w[k], op_w[k], sel_w[k], arith_w[k], shift_w[k]};
        always @(posedge clk) begin
            if ((req_valid_a[k] & req_ready_w[k]) != '0) hs_cyc <= cyc;
        end
        // Result only appears in its due cycle; any other cycle shows junk.
        assign dout = (cyc == hs_cyc + 1 + L) ? alu_f(alu_in) : (32'hDEAD_0000 ^ 32'(cyc));

        alu_scheduler #(.ALU_LATENCY(L)) u_dut (
            .clock        (clk),
            .reset        (reset),
            .req_valid    (req_valid_a[k]),
            .req_ready    (req_ready_w[k]),
            .req_cmd      (req_cmd_a[k]),
            .rsp_valid    (rsp_valid_w[k]),
            .rsp_ready    (rsp_ready_a[k]),
            .rsp_id       (rsp_id_w[k]),
            .rsp_data     (rsp_data_w[k]),
            .alu_data_1   (d1_w[k]),
            .alu_data_2   (d2_w[k]),
            .alu_op       (op_w[k]),
            .alu_sel      (sel_w[k]),
            .alu_arith    (arith_w[k]),
            .alu_shift    (shift_w[k]),
            .alu_data_out (dout)
        );
    end

    typedef struct {
        int          id;
        logic [31:0] data;
        int          due;
    } exp_t;

    typedef struct {
        int          id;
        alu_cmd_t    cmd;
        logic [31:0] exp;
    } vec_t;

    exp_t        sb[$];
    int          grants[$];
    int          gcyc[$];
    int          rsp_cyc[$];
    vec_t        vt [7];
    int          checks = 0;
    int          failures = 0;
    int          act = 0;
    int          ops_done = 0;
    int          stall = 0;
    bit          keep_valid = 0;
    bit          rsp_seen = 0;
    bit          cmd_pend = 0;
    logic [31:0] rsp_hold;
    logic [NR-1:0] pv;
    alu_cmd_t    pc [NR];
    logic [31:0] pe [NR];
    alu_cmd_t    cur_cmd [NI];
    alu_cmd_t    nxt_cmd;
    int          m_ptr [NI];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%0h want=%0h (inst %0d, cycle %0d)", name, got, want, act, cyc);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < NI; i++) begin
            req_valid_a[i] = '0;
            rsp_ready_a[i] = 1'b1;
        end
        req_valid_a[act] = pv;
        req_cmd_a[act]   = {pc[3], pc[2], pc[1], pc[0]};
        rsp_ready_a[act] = (stall == 0);
    endtask

    // One cycle of the active instance: observe at negedge, drive after posedge.
    task automatic step();
        int expg;
        bit hs;
        bit rv;
        hs   = 0;
        expg = 0;
        @(negedge clk);
        rv = rsp_valid_w[act];
        if (cmd_pend) begin
            cur_cmd[act] = nxt_cmd;
            cmd_pend = 0;
        end
        check("alu_cmd", {d1_w[act], d2_w[act], op_w[act], sel_w[act], arith_w[act], shift_w[act]},
              cur_cmd[act]);
        if (req_ready_w[act] != '0) begin
            check("ready_onehot", $onehot(req_ready_w[act]) && ((req_ready_w[act] & ~req_valid_a[act]) == '0), 1);
            expg = model_pick(req_valid_a[act], m_ptr[act]);
            check("grant", req_ready_w[act], (expg >= 0) ? (128'd1 << expg) : 128'd0);
            if (expg >= 0) begin
                m_ptr[act] = (expg + 1) % NR;
                grants.push_back(expg);
                gcyc.push_back(cyc);
                sb.push_back('{expg, pe[expg], cyc + 2 + lat_of(act)});
                nxt_cmd  = pc[expg];
                cmd_pend = 1;
                hs       = 1;
            end
        end
        if (rv) begin
            check("ready_in_resp", req_ready_w[act], 0);
            if (sb.size() == 0) begin
                check("rsp_unexpected", 1, 0);
            end else begin
                if (!rsp_seen) begin
                    check("rsp_latency", cyc, sb[0].due);
                    rsp_seen = 1;
                    rsp_hold = rsp_data_w[act];
                end else begin
                    check("rsp_stable", rsp_data_w[act], rsp_hold);
                end
                if (rsp_ready_a[act]) begin
                    check("rsp_id", rsp_id_w[act], sb[0].id);
                    check("rsp_data", rsp_data_w[act], sb[0].data);
                    void'(sb.pop_front());
                    rsp_seen = 0;
                    ops_done++;
                    rsp_cyc.push_back(cyc);
                end
            end
        end
        @(posedge clk);
        #1;
        if (rv && stall > 0) stall--;
        if (hs) begin
            if (keep_valid) begin
                pc[expg] = rand_cmd();
                pe[expg] = alu_f(pc[expg]);
            end else begin
                pv[expg] = 1'b0;
            end
        end
        apply();
    endtask

    task automatic run(input int n, input int budget);
        int target;
        int b;
        target = ops_done + n;
        b = 0;
        while (ops_done < target && b < budget) begin
            step();
            b++;
        end
        check("run_complete", ops_done >= target, 1);
    endtask

    task automatic do_reset(input int n, input bit chk);
        reset = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (chk) begin
                for (int i = 0; i < NI; i++) begin
                    check("reset_ready", req_ready_w[i], 0);
                    if (c > 0) begin
                        check("reset_rsp_valid", rsp_valid_w[i], 0);
                        check("reset_rsp", {rsp_id_w[i], rsp_data_w[i]}, 0);
                        check("reset_alu", {d1_w[i], d2_w[i], op_w[i], sel_w[i], arith_w[i], shift_w[i]}, 0);
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        for (int i = 0; i < NI; i++) begin
            m_ptr[i]   = 0;
            cur_cmd[i] = '0;
        end
        sb.delete();
        grants.delete();
        gcyc.delete();
        rsp_cyc.delete();
        rsp_seen   = 0;
        cmd_pend   = 0;
        stall      = 0;
        keep_valid = 0;
        pv         = '0;
        apply();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        vt[0] = '{0, '{32'd5,         32'd3,         3'd0, 3'd0, 1'b0, 1'b0}, 32'd8};
        vt[1] = '{1, '{32'd10,        32'd4,         3'd1, 3'd2, 1'b1, 1'b0}, 32'd6};
        vt[2] = '{2, '{32'h0000_F0F0, 32'h0000_FF00, 3'd2, 3'd1, 1'b0, 1'b1}, 32'h0000_F000};
        vt[3] = '{3, '{32'h0000_0F00, 32'h0000_00F0, 3'd3, 3'd3, 1'b1, 1'b1}, 32'h0000_0FF0};
        vt[4] = '{0, '{32'hFFFF_FFFF, 32'd1,         3'd0, 3'd7, 1'b0, 1'b0}, 32'd0};
        vt[5] = '{2, '{32'hAAAA_AAAA, 32'hFFFF_FFFF, 3'd4, 3'd4, 1'b0, 1'b1}, 32'h5555_5555};
        vt[6] = '{3, '{32'h0000_1234, 32'h0000_0001, 3'd7, 3'd5, 1'b1, 1'b1}, 32'h0000_1234};

        // Reset with every requester asserting valid.
        reset = 1'b0;
        for (int i = 0; i < NR; i++) begin
            pc[i] = rand_cmd();
            pe[i] = alu_f(pc[i]);
        end
        for (int i = 0; i < NI; i++) begin
            req_valid_a[i] = 4'hF;
            req_cmd_a[i]   = {pc[3], pc[2], pc[1], pc[0]};
            rsp_ready_a[i] = 1'b0;
        end
        do_reset(3, 1);

        for (int k = 0; k < NI; k++) begin
            act = k;
            do_reset(1, 0);
            for (int v = 0; v < 7; v++) begin
                pv = 4'(1 << vt[v].id);
                pc[vt[v].id] = vt[v].cmd;
                pe[vt[v].id] = vt[v].exp;
                apply();
                run(1, 20);
            end

            // All four requesters held valid: strict rotation from pointer 0.
            do_reset(1, 0);
            keep_valid = 1;
            pv = 4'hF;
            for (int i = 0; i < NR; i++) begin
                pc[i] = rand_cmd();
                pe[i] = alu_f(pc[i]);
            end
            apply();
            run(8, 8 * (4 + lat_of(k)) + 10);
            check("fair_count", grants.size(), 8);
            for (int i = 0; i < grants.size() && i < 8; i++) begin
                check("fair_order", grants[i], i % 4);
            end
            keep_valid = 0;
            pv = '0;
            apply();
        end

        // Backpressure: response held 10 cycles while requester 1 waits.
        act = 0;
        do_reset(1, 0);
        pv = 4'b0011;
        pc[0] = rand_cmd(); pe[0] = alu_f(pc[0]);
        pc[1] = rand_cmd(); pe[1] = alu_f(pc[1]);
        stall = 10;
        apply();
        run(2, 40);
        check("bp_grants", grants.size(), 2);
        if (grants.size() == 2 && rsp_cyc.size() >= 1) begin
            check("bp_order", {grants[0], grants[1]}, {32'd0, 32'd1});
            check("bp_hold_len", rsp_cyc[0] - gcyc[0], 13);
            check("bp_regrant", gcyc[1], rsp_cyc[0] + 1);
        end

        // Wrap and skip: pointer at 3 with requesters 0 and 2 pending.
        do_reset(1, 0);
        pv = 4'b0100;
        pc[2] = rand_cmd(); pe[2] = alu_f(pc[2]);
        apply();
        run(1, 20);
        pv = 4'b0101;
        pc[0] = rand_cmd(); pe[0] = alu_f(pc[0]);
        pc[2] = rand_cmd(); pe[2] = alu_f(pc[2]);
        apply();
        run(2, 20);
        check("wrap_grants", grants.size(), 3);
        if (grants.size() == 3) begin
            check("wrap_order", {grants[0], grants[1], grants[2]}, {32'd2, 32'd0, 32'd2});
        end

        // Reset during WAIT abandons the operation and clears the pointer.
        act = 2;
        do_reset(1, 0);
        pv = 4'b0001;
        pc[0] = rand_cmd(); pe[0] = alu_f(pc[0]);
        apply();
        for (int c = 0; c < 5 && grants.size() == 0; c++) step();
        check("midop_grant", grants.size(), 1);
        step();
        step();
        do_reset(2, 1);
        n0 = ops_done;
        for (int c = 0; c < 10; c++) step();
        check("midop_no_rsp", ops_done, n0);
        pv = 4'b0011;
        pc[0] = rand_cmd(); pe[0] = alu_f(pc[0]);
        pc[1] = rand_cmd(); pe[1] = alu_f(pc[1]);
        apply();
        run(1, 20);
        check("midop_ptr", (grants.size() > 0) ? grants[0] : -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
